// File: rtl/wb_core_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_core_arbiter_pkg
// Shared definitions for the dual-core Wishbone data-memory arbiter:
//   state_e          - arbiter FSM state encoding
//   ABORT_DATA       - load data returned on a bus error or timeout
//   DEFAULT_TIMEOUT  - default bus wait budget, in cycles after STB
// -----------------------------------------------------------------------------
package wb_core_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] ABORT_DATA      = 32'hDEAD_BEEF;
  localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational; only the
// last-grant pointer is registered.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-low reset (last-grant -> port 1)
//   req     in   [1:0] request vector, bit N = port N
//   take    in   the current grant is accepted this cycle; updates pointer
//   gnt_id  out  index of the granted port (meaningful when req != 0)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_id = 1'b0;
    last_d = last_q;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      // Contention: the port that was not granted last wins.
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
    if (take && (req != 2'b00)) begin
      last_d = gnt_id;
    end
  end

  // Pointer resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wb_core_arbiter.sv
// -----------------------------------------------------------------------------
// wb_core_arbiter
// Arbitrates two core data-memory ports onto a single Wishbone classic
// master. One access at a time: IDLE grants, BUS runs the Wishbone cycle,
// DONE returns a one-cycle ready pulse to the granted core.
// Parameters:
//   TIMEOUT  bus wait cycles after STB before a forced abort (1..65535)
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   cN_req/we/addr/wdata/be      core N request (held until cN_ready)
//   cN_ready, cN_rdata           core N completion pulse and load data
//   wb_cyc_o/stb_o/we_o          Wishbone controls
//   wb_adr_o/dat_o/sel_o         Wishbone address, write data, byte select
//   wb_dat_i/ack_i/err_i         Wishbone slave response
//   bus_fault                    sticky error/timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module wb_core_arbiter
  import wb_core_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic [3:0]  c0_be,
  output logic        c0_ready,
  output logic [31:0] c0_rdata,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  input  logic [3:0]  c1_be,
  output logic        c1_ready,
  output logic [31:0] c1_rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_fault
);

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic        gnt_id_q, gnt_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;

  logic        arb_id;
  logic        take;
  logic        timeout_hit;
  logic        in_bus;
  logic        in_done;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({c1_req, c0_req}),
    .take   (take),
    .gnt_id (arb_id)
  );

  // The counter holds the number of BUS cycles already elapsed, so the
  // abort fires at the end of the TIMEOUT-th STB cycle.
  assign timeout_hit = (({1'b0, cnt_q} + 17'd1) == TIMEOUT_L);

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c0_req || c1_req) begin
          take     = 1'b1;
          gnt_id_d = arb_id;
          we_d     = arb_id ? c1_we    : c0_we;
          adr_d    = arb_id ? c1_addr  : c0_addr;
          wdat_d   = arb_id ? c1_wdata : c0_wdata;
          sel_d    = arb_id ? c1_be    : c0_be;
          cnt_d    = 16'd0;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        // Error wins over a simultaneous ack; timeout takes the same path.
        if (wb_err_i || timeout_hit) begin
          rdata_d = ABORT_DATA;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else if (wb_ack_i) begin
          rdata_d = we_q ? 32'd0 : wb_dat_i;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state: cleared asynchronously so the bus drops at once on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= 1'b0;
      cnt_q    <= 16'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  // Latched transaction payload: only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    adr_q   <= adr_d;
    wdat_q  <= wdat_d;
    sel_q   <= sel_d;
    rdata_q <= rdata_d;
  end

  assign in_bus  = (state_q == ST_BUS);
  assign in_done = (state_q == ST_DONE);

  assign wb_cyc_o = in_bus;
  assign wb_stb_o = in_bus;
  assign wb_we_o  = in_bus & we_q;
  assign wb_adr_o = in_bus ? adr_q  : 32'd0;
  assign wb_dat_o = in_bus ? wdat_q : 32'd0;
  assign wb_sel_o = in_bus ? sel_q  : 4'd0;

  assign c0_ready = in_done & ~gnt_id_q;
  assign c1_ready = in_done &  gnt_id_q;
  assign c0_rdata = c0_ready ? rdata_q : 32'd0;
  assign c1_rdata = c1_ready ? rdata_q : 32'd0;

  assign bus_fault = fault_q;

endmodule

// File: tb/tb_wb_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_core_arbiter
// Directed bench for wb_core_arbiter (TIMEOUT = 4). Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_wb_core_arbiter;

  logic        clk;
  logic        rst;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic [3:0]  c0_be, c1_be;
  logic        c0_ready, c1_ready;
  logic [31:0] c0_rdata, c1_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        bus_fault;

  int n_tests = 0;
  int n_fail  = 0;

  wb_core_arbiter #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .c0_req   (c0_req),
    .c0_we    (c0_we),
    .c0_addr  (c0_addr),
    .c0_wdata (c0_wdata),
    .c0_be    (c0_be),
    .c0_ready (c0_ready),
    .c0_rdata (c0_rdata),
    .c1_req   (c1_req),
    .c1_we    (c1_we),
    .c1_addr  (c1_addr),
    .c1_wdata (c1_wdata),
    .c1_be    (c1_be),
    .c1_ready (c1_ready),
    .c1_rdata (c1_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .bus_fault(bus_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    c0_req = r; c0_we = we; c0_addr = a; c0_wdata = d; c0_be = be;
  endtask

  task automatic req1(input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    c1_req = r; c1_we = we; c1_addr = a; c1_wdata = d; c1_be = be;
  endtask

  // Ack for one cycle (currently in BUS); returns positioned in DONE.
  task automatic ack_with(input logic [31:0] d);
    wb_ack_i = 1'b1;
    wb_dat_i = d;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'd0;
  endtask

  initial begin
    rst = 1'b0;
    req0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    req1(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    // Reset state, with a request present that must be ignored
    tick();
    c0_req = 1'b1;
    tick();
    chk("rst_cyc",   32'(wb_cyc_o),  32'd0);
    chk("rst_stb",   32'(wb_stb_o),  32'd0);
    chk("rst_adr",   wb_adr_o,       32'd0);
    chk("rst_rdy0",  32'(c0_ready),  32'd0);
    chk("rst_rdy1",  32'(c1_ready),  32'd0);
    chk("rst_fault", 32'(bus_fault), 32'd0);
    c0_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_stb", 32'(wb_stb_o), 32'd0);

    // Contention from reset: c0 first; c0 re-requests at once, so c1 wins next
    req0(1'b1, 1'b0, 32'h40, 32'd0, 4'hF);
    req1(1'b1, 1'b0, 32'h80, 32'd0, 4'hF);
    tick();
    chk("rr1_stb", 32'(wb_stb_o), 32'd1);
    chk("rr1_adr", wb_adr_o,      32'h40);
    ack_with(32'h0000_00C0);
    chk("rr1_rdy0",  32'(c0_ready), 32'd1);
    chk("rr1_rdy1",  32'(c1_ready), 32'd0);
    chk("rr1_data0", c0_rdata,      32'h0000_00C0);
    chk("rr1_cyc",   32'(wb_cyc_o), 32'd0);
    c0_addr = 32'h44;
    tick();
    chk("rr1_idle_stb", 32'(wb_stb_o), 32'd0);
    tick();
    chk("rr2_stb", 32'(wb_stb_o), 32'd1);
    chk("rr2_adr", wb_adr_o,      32'h80);
    ack_with(32'h0000_00C1);
    chk("rr2_rdy1",  32'(c1_ready), 32'd1);
    chk("rr2_rdy0",  32'(c0_ready), 32'd0);
    chk("rr2_data1", c1_rdata,      32'h0000_00C1);
    c1_req = 1'b0;
    tick();
    tick();
    chk("rr3_adr", wb_adr_o, 32'h44);
    ack_with(32'h0000_00C2);
    chk("rr3_rdy0", 32'(c0_ready), 32'd1);
    c0_req = 1'b0;
    tick();

    // c0 read of 0x100, slave acks 2 cycles after STB
    req0(1'b1, 1'b0, 32'h100, 32'd0, 4'hF);
    tick();
    chk("rd_stb0", 32'(wb_stb_o), 32'd1);
    chk("rd_cyc0", 32'(wb_cyc_o), 32'd1);
    chk("rd_we",   32'(wb_we_o),  32'd0);
    chk("rd_adr",  wb_adr_o,      32'h100);
    tick();
    chk("rd_stb1", 32'(wb_stb_o), 32'd1);
    chk("rd_rdy_early", 32'(c0_ready), 32'd0);
    tick();
    ack_with(32'h1234_5678);
    chk("rd_rdy0",  32'(c0_ready), 32'd1);
    chk("rd_data0", c0_rdata,      32'h1234_5678);
    chk("rd_rdy1",  32'(c1_ready), 32'd0);
    chk("rd_stb_done", 32'(wb_stb_o), 32'd0);
    c0_req = 1'b0;
    tick();
    chk("rd_rdy_once", 32'(c0_ready), 32'd0);
    chk("rd_data_idle", c0_rdata,     32'd0);

    // c1 write: Wishbone outputs stable over the whole BUS phase
    req1(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_we",  32'(wb_we_o),  32'd1);
      chk("wr_adr", wb_adr_o,      32'h20);
      chk("wr_dat", wb_dat_o,      32'hA5A5_A5A5);
      chk("wr_sel", 32'(wb_sel_o), 32'h3);
    end
    ack_with(32'hFFFF_FFFF);
    chk("wr_rdy1",  32'(c1_ready), 32'd1);
    chk("wr_rdy0",  32'(c0_ready), 32'd0);
    chk("wr_data1", c1_rdata,      32'd0);
    chk("wr_we_done", 32'(wb_we_o), 32'd0);
    chk("wr_fault", 32'(bus_fault), 32'd0);
    c1_req = 1'b0;
    tick();

    // Timeout (4 cycles, no ack)
    req0(1'b1, 1'b0, 32'h200, 32'd0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_stb",  32'(wb_stb_o), 32'd1);
      chk("to_rdy",  32'(c0_ready), 32'd0);
    end
    tick();
    chk("to_rdy0",  32'(c0_ready),  32'd1);
    chk("to_data",  c0_rdata,       32'hDEAD_BEEF);
    chk("to_fault", 32'(bus_fault), 32'd1);
    chk("to_stb_done", 32'(wb_stb_o), 32'd0);
    c0_req = 1'b0;
    tick();

    // Good transfer afterwards: fault stays set
    req1(1'b1, 1'b0, 32'h300, 32'd0, 4'hF);
    tick();
    ack_with(32'h0000_5555);
    chk("good_rdy1",  32'(c1_ready),  32'd1);
    chk("good_data",  c1_rdata,       32'h0000_5555);
    chk("good_fault", 32'(bus_fault), 32'd1);
    c1_req = 1'b0;
    tick();

    // err and ack together: error path
    req0(1'b1, 1'b0, 32'h310, 32'd0, 4'hF);
    tick();
    wb_err_i = 1'b1;
    ack_with(32'h1111_1111);
    wb_err_i = 1'b0;
    chk("err_rdy0",  32'(c0_ready),  32'd1);
    chk("err_data",  c0_rdata,       32'hDEAD_BEEF);
    chk("err_fault", 32'(bus_fault), 32'd1);
    c0_req = 1'b0;
    tick();

    // Reset two cycles into BUS: bus drops without a clock edge
    req0(1'b1, 1'b0, 32'h400, 32'd0, 4'hF);
    tick();
    tick();
    chk("ar_stb_pre", 32'(wb_stb_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_cyc",   32'(wb_cyc_o),  32'd0);
    chk("ar_stb",   32'(wb_stb_o),  32'd0);
    chk("ar_fault", 32'(bus_fault), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_rdy0", 32'(c0_ready), 32'd0);
      chk("ar_stb_hold", 32'(wb_stb_o), 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("ar_regrant_stb", 32'(wb_stb_o), 32'd1);
    chk("ar_regrant_adr", wb_adr_o,      32'h400);
    chk("ar_no_rdy",      32'(c0_ready), 32'd0);
    ack_with(32'h0000_0400);
    chk("ar_rdy0", 32'(c0_ready), 32'd1);
    chk("ar_data", c0_rdata,      32'h0000_0400);
    c0_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
